// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic CMD_WE_NONE = 1'b0;
  localparam logic [1:0] CMD_SIZE_NONE = SZ_BYTE;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshakes of the arbiter
// Ports: fetch (if_req/if_addr in, if_gnt/if_rvalid/if_rdata/if_stall out),
// data (d_req/d_we/d_size/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata/d_stall out),
// memory (mem_req/mem_we/mem_size/mem_addr/mem_wdata out, mem_rvalid/mem_rdata in);
// slave is the arbiter's view, master the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int DATAW = 32
);
  logic             if_req;
  logic [DATAW-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [DATAW-1:0] if_rdata;
  logic             if_stall;
  logic             d_req;
  logic             d_we;
  logic [1:0]       d_size;
  logic [DATAW-1:0] d_addr;
  logic [DATAW-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [DATAW-1:0] d_rdata;
  logic             d_stall;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic [DATAW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [DATAW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata, d_stall,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata, d_stall,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_wait_ctr.sv
// mem_arb_wait_ctr: saturating wait counter with clear, enable and timeout compare
// Ports: clock; reset (sync, active-high); clr zeroes the count and wins over en;
// en advances the count, which stops at TIMEOUT; tmo is high while the count equals TIMEOUT.
module mem_arb_wait_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tmo
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  logic [CW-1:0] count;
  always_ff @(posedge clock)
    count <= (reset | clr) ? '0 : (en & (count != LIMIT)) ? count + CW'(1) : count;
  assign tmo = count == LIMIT;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-in-flight arbiter of a single memory port between fetch and data
// Ports: clock; reset (sync, active-high); bus (mem_port_arbiter_if.slave) with the fetch,
// data and memory handshakes; err_spurious / err_timeout are sticky error flags.
// Build option MEM_ARB_RR_EN: round-robin between requesters instead of data-over-fetch priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              err_spurious,
  output logic              err_timeout
);
  state_t state, state_nx;
  owner_t win;
  logic busy, tmo, done, free, gnt, ig, dg, irv, drv;
  assign busy = state != IDLE;
  assign done = busy & (bus.mem_rvalid | tmo);
  // A timeout outranks a response landing in the same cycle and blocks re-grant.
  assign free = !busy | (bus.mem_rvalid & !tmo);
  assign gnt  = !reset & free & (bus.if_req | bus.d_req);
`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
  assign win = (bus.if_req & bus.d_req) ? ((last_owner == OWN_IF) ? OWN_D : OWN_IF)
                                        : (bus.d_req ? OWN_D : OWN_IF);
  always_ff @(posedge clock)
    if (reset) last_owner <= OWN_IF;
    else if (gnt) last_owner <= win;
`else
  assign win = bus.d_req ? OWN_D : OWN_IF;
`endif
  // The counter sits at zero while idle and restarts on every completion, so a
  // back-to-back grant gets a full TIMEOUT window.
  mem_arb_wait_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clock,
    .reset,
    .clr(!busy | done),
    .en (busy),
    .tmo
  );
  always_ff @(posedge clock)
    if (reset) begin
      state        <= IDLE;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nx;
      err_spurious <= err_spurious | (!busy & bus.mem_rvalid);
      err_timeout  <= err_timeout | (busy & tmo);
    end
  // Outputs are forced low during reset so a held request cannot leak a grant.
  always_comb begin
    ig            = gnt & (win == OWN_IF);
    dg            = gnt & (win == OWN_D);
    irv           = !reset & done & (state == BUSY_IF);
    drv           = !reset & done & (state == BUSY_D);
    state_nx      = gnt ? (dg ? BUSY_D : BUSY_IF) : done ? IDLE : state;
    bus.if_gnt    = ig;
    bus.d_gnt     = dg;
    bus.mem_req   = gnt;
    bus.mem_we    = dg ? bus.d_we : CMD_WE_NONE;
    bus.mem_size  = dg ? bus.d_size : ig ? SZ_WORD : CMD_SIZE_NONE;
    bus.mem_addr  = dg ? bus.d_addr : ig ? bus.if_addr : '0;
    bus.mem_wdata = dg ? bus.d_wdata : '0;
    bus.if_rvalid = irv;
    bus.d_rvalid  = drv;
    bus.if_rdata  = (irv & !tmo) ? bus.mem_rdata : '0;
    bus.d_rdata   = (drv & !tmo) ? bus.mem_rdata : '0;
    bus.if_stall  = !reset & bus.if_req & !irv;
    bus.d_stall   = !reset & bus.d_req & !drv;
  end
endmodule
